spart_driver: RTL and testbench



---
 rtl/spart_pkg.sv | 33 +++
 rtl/spart_driver.sv | 187 ++++++++++++++++++
 tb/tb_spart_driver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared types and helpers for the spart bus initiator.
package spart_pkg;

  // Bus initiator sequencing states
  typedef enum logic [2:0] {
    CFG_LO   = 3'd0,
    CFG_HI   = 3'd1,
    IDLE     = 3'd2,
    RD       = 3'd3,
    RD_GAP   = 3'd4,
    WAIT_TBR = 3'd5,
    WR       = 3'd6,
    WR_GAP   = 3'd7
  } drv_state_t;

  // spart register map
  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Baud divisor: clock / (base baud << cfg), truncated, kept to 16 bits
  function automatic logic [15:0] baud_div(input logic [1:0]  cfg,
                                           input int unsigned clk_freq,
                                           input int unsigned baud0);
    logic [31:0] baud;
    logic [31:0] quot;
    baud = baud0 << cfg;
    quot = clk_freq / baud;
    return quot[15:0];
  endfunction

endpackage

// File: rtl/spart_driver.sv
// Processor-side bus initiator for spart: programs the baud divisor from the
// switches, then echoes every received byte back out.
// Bus outputs are registered from the current state, so each bus cycle is
// presented in the clock after the state is entered and is glitch-free.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 32'd50_000_000,
  parameter int unsigned BAUD0    = 32'd9600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  br_cfg,
  input  logic        rda,
  input  logic        tbr,
  output logic        iocs,
  output logic        iorw,
  output logic [1:0]  ioaddr,
  inout  wire  [7:0]  databus,
  output logic [7:0]  last_byte,
  output logic [15:0] byte_cnt
);

  drv_state_t  r_state;
  drv_state_t  w_next_state;

  logic [1:0]  r_cfg_s1;
  logic [1:0]  r_cfg_s2;
  logic [1:0]  r_cfg_q;
  logic [1:0]  r_cfg_snap;
  logic        r_pending_cfg;
  logic [15:0] w_div;
  logic [7:0]  r_div_hi;

  logic        w_iocs;
  logic        w_iorw;
  logic [1:0]  w_ioaddr;
  logic [7:0]  w_dout;

  logic        r_iocs;
  logic        r_iorw;
  logic [1:0]  r_ioaddr;
  logic [7:0]  r_dout;
  logic [7:0]  r_rx_hold;
  logic [7:0]  r_last_byte;
  logic [15:0] r_byte_cnt;

  assign w_div = baud_div(r_cfg_q, CLK_FREQ, BAUD0);

  // Synchronise the switches and flag any change as a pending reconfiguration.
  // A change always wins over the clear, and the clear only happens if the
  // value actually written is still current, so no change is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_s1      <= 2'b00;
      r_cfg_s2      <= 2'b00;
      r_cfg_q       <= 2'b00;
      r_pending_cfg <= 1'b0;
    end else begin
      r_cfg_s1 <= br_cfg;
      r_cfg_s2 <= r_cfg_s1;
      if (r_cfg_s2 != r_cfg_q) begin
        r_cfg_q       <= r_cfg_s2;
        r_pending_cfg <= 1'b1;
      end else if ((r_state == CFG_HI) && (r_cfg_q == r_cfg_snap)) begin
        r_pending_cfg <= 1'b0;
      end
    end
  end

  // Snapshot the divisor when the low byte goes out so both halves match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_hi   <= 8'h00;
      r_cfg_snap <= 2'b00;
    end else if (r_state == CFG_LO) begin
      r_div_hi   <= w_div[15:8];
      r_cfg_snap <= r_cfg_q;
    end
  end

  // Next-state and bus-cycle decode for the current state
  always_comb begin
    w_next_state = r_state;
    w_iocs       = 1'b0;
    w_iorw       = 1'b1;
    w_ioaddr     = ADDR_BUF;
    w_dout       = 8'h00;
    case (r_state)
      CFG_LO: begin
        w_iocs       = 1'b1;
        w_iorw       = 1'b0;
        w_ioaddr     = ADDR_DBL;
        w_dout       = w_div[7:0];
        w_next_state = CFG_HI;
      end
      CFG_HI: begin
        w_iocs       = 1'b1;
        w_iorw       = 1'b0;
        w_ioaddr     = ADDR_DBH;
        w_dout       = r_div_hi;
        w_next_state = IDLE;
      end
      IDLE: begin
        if (r_pending_cfg) begin
          w_next_state = CFG_LO;
        end else if (rda) begin
          w_next_state = RD;
        end else begin
          w_next_state = IDLE;
        end
      end
      RD: begin
        w_iocs       = 1'b1;
        w_iorw       = 1'b1;
        w_ioaddr     = ADDR_BUF;
        w_next_state = RD_GAP;
      end
      RD_GAP: begin
        w_next_state = WAIT_TBR;
      end
      WAIT_TBR: begin
        if (tbr) begin
          w_next_state = WR;
        end else begin
          w_next_state = WAIT_TBR;
        end
      end
      WR: begin
        w_iocs       = 1'b1;
        w_iorw       = 1'b0;
        w_ioaddr     = ADDR_BUF;
        w_dout       = r_rx_hold;
        w_next_state = WR_GAP;
      end
      WR_GAP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = CFG_LO;
      end
    endcase
  end

  // State register and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= CFG_LO;
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= ADDR_BUF;
      r_dout   <= 8'h00;
    end else begin
      r_state  <= w_next_state;
      r_iocs   <= w_iocs;
      r_iorw   <= w_iorw;
      r_ioaddr <= w_ioaddr;
      r_dout   <= w_dout;
    end
  end

  // Capture read data and account for completed echo writes on closing edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_hold   <= 8'h00;
      r_last_byte <= 8'h00;
      r_byte_cnt  <= 16'h0000;
    end else begin
      if (r_iocs && r_iorw) begin
        r_rx_hold <= databus;
      end
      if (r_iocs && !r_iorw && (r_ioaddr == ADDR_BUF)) begin
        r_last_byte <= r_rx_hold;
        r_byte_cnt  <= r_byte_cnt + 16'd1;
      end
    end
  end

  // Only drive the shared bus during our own write strobe
  assign databus   = (r_iocs && !r_iorw) ? r_dout : 8'hzz;
  assign iocs      = r_iocs;
  assign iorw      = r_iorw;
  assign ioaddr    = r_ioaddr;
  assign last_byte = r_last_byte;
  assign byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_spart_driver.sv
// Scoreboard bench for spart_driver: stimulus queues expected bus cycles,
// a negedge monitor pops and compares every strobe the DUT issues.
module tb_spart_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  br_cfg;
  logic        rda;
  logic        tbr;
  logic        iocs;
  logic        iorw;
  logic [1:0]  ioaddr;
  wire  [7:0]  databus;
  logic [7:0]  last_byte;
  logic [15:0] byte_cnt;
  logic [7:0]  m_rx_data;

  typedef struct packed {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
  } bus_t;

  bus_t exp_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   cyc        = 0;
  int   rd_cyc     = -1;
  int   wr_cyc     = -1;
  int   cfg_lo_cyc = -1;

  always #5 clk = ~clk;

  // Undriven bus reads back as 8'hFF
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu_i (databus[g]);
  end

  // spart model: supplies receive data during a read strobe
  assign databus = (iocs && iorw) ? m_rx_data : 8'hzz;

  spart_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .br_cfg    (br_cfg),
    .rda       (rda),
    .tbr       (tbr),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .databus   (databus),
    .last_byte (last_byte),
    .byte_cnt  (byte_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic push(input logic rw, input logic [1:0] addr, input logic [7:0] data);
    bus_t e;
    e.rw = rw; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // One-cycle rda pulse, starting at a negedge; returns the cycle it was raised
  task automatic pulse_rda(output int c);
    rda = 1'b1;
    c   = cyc;
    @(negedge clk);
    rda = 1'b0;
  endtask

  // Monitor: every strobe must match the next expected bus cycle
  always @(negedge clk) begin : mon
    bus_t e;
    if (rst_n === 1'b1 && iocs === 1'b1) begin
      if (iorw === 1'b1) rd_cyc = cyc;
      else if (ioaddr === 2'b00) wr_cyc = cyc;
      else if (ioaddr === 2'b10) cfg_lo_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got rw=%0b addr=%0b data=%0h, expected no strobe",
                 iorw, ioaddr, databus);
      end else begin
        e = exp_q.pop_front();
        check("bus_xact", {21'd0, iorw, ioaddr, databus}, {21'd0, e});
      end
    end
  end

  initial begin
    int c;
    int t;
    int rel;
    int bad;
    rst_n = 1'b0; br_cfg = 2'b00; rda = 1'b0; tbr = 1'b0; m_rx_data = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_iocs",   {31'd0, iocs},   32'd0);
    check("rst_iorw",   {31'd0, iorw},   32'd1);
    check("rst_ioaddr", {30'd0, ioaddr}, 32'd0);
    check("rst_bus_z",  {24'd0, databus}, 32'hFF);
    check("rst_last",   {24'd0, last_byte}, 32'd0);
    check("rst_cnt",    {16'd0, byte_cnt},  32'd0);

    // Divisor 5208 = 16'h1458 right after release
    push(1'b0, 2'b10, 8'h58);
    push(1'b0, 2'b11, 8'h14);
    rel = cyc;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("cfg_lo_latency", cfg_lo_cyc, rel + 1);
    check("cfg_drain", exp_q.size(), 32'd0);

    // Basic echo with tbr already high
    m_rx_data = 8'h41; tbr = 1'b1;
    push(1'b1, 2'b00, 8'h41);
    push(1'b0, 2'b00, 8'h41);
    pulse_rda(c);
    repeat (8) @(negedge clk);
    check("rd_latency", rd_cyc, c + 2);
    check("wr_after_rd", wr_cyc, rd_cyc + 3);
    check("echo1_last", {24'd0, last_byte}, 32'h41);
    check("echo1_cnt",  {16'd0, byte_cnt},  32'd1);
    check("echo1_drain", exp_q.size(), 32'd0);

    // tbr held low: no write, bus released, then write one cycle after tbr
    tbr = 1'b0; m_rx_data = 8'hC3;
    push(1'b1, 2'b00, 8'hC3);
    pulse_rda(c);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (iocs !== 1'b0 || databus !== 8'hFF) bad++;
    end
    check("tbr_hold_idle", bad, 32'd0);
    push(1'b0, 2'b00, 8'hC3);
    tbr = 1'b1;
    t = cyc;
    repeat (6) @(negedge clk);
    check("tbr_rise_wr", wr_cyc, t + 2);
    check("echo2_last", {24'd0, last_byte}, 32'hC3);
    check("echo2_cnt",  {16'd0, byte_cnt},  32'd2);

    // br_cfg change while waiting for tbr: echo finishes, then 651 = 16'h028B
    tbr = 1'b0; m_rx_data = 8'h5A;
    push(1'b1, 2'b00, 8'h5A);
    pulse_rda(c);
    repeat (3) @(negedge clk);
    br_cfg = 2'b11;
    repeat (6) @(negedge clk);
    check("cfg_held_in_wait", exp_q.size(), 32'd0);
    push(1'b0, 2'b00, 8'h5A);
    push(1'b0, 2'b10, 8'h8B);
    push(1'b0, 2'b11, 8'h02);
    tbr = 1'b1;
    repeat (10) @(negedge clk);
    tbr = 1'b0;
    check("echo3_drain", exp_q.size(), 32'd0);
    check("echo3_last", {24'd0, last_byte}, 32'h5A);
    check("echo3_cnt",  {16'd0, byte_cnt},  32'd3);

    // Reset asserted in the middle of the write strobe
    m_rx_data = 8'h77;
    push(1'b1, 2'b00, 8'h77);
    pulse_rda(c);
    repeat (3) @(negedge clk);
    tbr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("wr_strobe_live", {31'd0, iocs}, 32'd1);
    check("wr_strobe_data", {24'd0, databus}, 32'h77);
    rst_n = 1'b0;
    #1;
    check("arst_iocs",  {31'd0, iocs}, 32'd0);
    check("arst_iorw",  {31'd0, iorw}, 32'd1);
    check("arst_bus_z", {24'd0, databus}, 32'hFF);
    check("arst_cnt",   {16'd0, byte_cnt},  32'd0);
    check("arst_last",  {24'd0, last_byte}, 32'd0);
    tbr = 1'b0;
    repeat (3) @(negedge clk);
    // Synchroniser restarts at 00, so 5208 goes out first, then 651
    push(1'b0, 2'b10, 8'h58);
    push(1'b0, 2'b11, 8'h14);
    push(1'b0, 2'b10, 8'h8B);
    push(1'b0, 2'b11, 8'h02);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_cfg_drain", exp_q.size(), 32'd0);

    // Counter wrap
    force dut.r_byte_cnt = 16'hFFFF;
    #1;
    release dut.r_byte_cnt;
    check("cnt_preload", {16'd0, byte_cnt}, 32'hFFFF);
    m_rx_data = 8'h99; tbr = 1'b1;
    push(1'b1, 2'b00, 8'h99);
    push(1'b0, 2'b00, 8'h99);
    pulse_rda(c);
    repeat (8) @(negedge clk);
    check("cnt_wrap", {16'd0, byte_cnt}, 32'd0);
    check("wrap_last", {24'd0, last_byte}, 32'h99);
    check("wrap_drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
